// File: rtl/id_sampler_n.sv
// id_sampler_n
//   Discrete-input sampler. On SAMPLE, one of NSRC source groups (NCH bits each)
//   is either copied into the DM latch or OR-ed into it. The latch can be
//   shifted out serially, LSB first, on SER.
//
// Ports
//   SIM_CLK   in   1          sole clock, rising edge
//   SIM_RST   in   1          asynchronous active-low reset
//   SRC_DATA  in   NSRC*NCH   source groups, group k at [k*NCH +: NCH]
//   SRC_SEL   in   SELW       group index for the current sample
//   SAMPLE    in   1          one-cycle sample strobe
//   ACCUM     in   1          1 = OR into latch, 0 = overwrite
//   CLEAR     in   1          synchronous latch clear (wins over SAMPLE)
//   READ      in   1          one-cycle serial readout request
//   DM        out  NCH        latched discretes
//   DMN       out  NCH        ~DM
//   SER       out  1          serial data, 0 when idle
//   BUSY      out  1          readout in progress
//   VALID     out  1          a sample has been taken since the last CLEAR/reset
//   SELERR    out  1          sticky: a SAMPLE was seen with SRC_SEL >= NSRC
//
// Build option
//   ID_SAMPLER_PARITY_EN  when defined, an odd-parity bit over the loaded data
//                         follows the NCH data bits (frame of NCH+1 bits).
module id_sampler_n #(
  parameter int NCH  = 6,
  parameter int NSRC = 9,
  localparam int SELW = $clog2(NSRC),
  localparam int SNW  = $clog2(NCH + 2)
) (
  input  logic                  SIM_CLK,
  input  logic                  SIM_RST,
  input  logic [NSRC*NCH-1:0]   SRC_DATA,
  input  logic [SELW-1:0]       SRC_SEL,
  input  logic                  SAMPLE,
  input  logic                  ACCUM,
  input  logic                  CLEAR,
  input  logic                  READ,
  output logic [NCH-1:0]        DM,
  output logic [NCH-1:0]        DMN,
  output logic                  SER,
  output logic                  BUSY,
  output logic                  VALID,
  output logic                  SELERR
);

`ifdef ID_SAMPLER_PARITY_EN
  localparam int FW = NCH + 1;
`else
  localparam int FW = NCH;
`endif

  localparam logic [SNW-1:0] FRAME_CNT = SNW'(FW);
  localparam logic [SELW:0]  NSRC_W    = NSRC[SELW:0];

  typedef enum logic {IDLE, SHIFT} state_t;

  // Odd parity: the bit that makes the total count of ones odd.
  function automatic logic odd_par(input logic [NCH-1:0] d);
    return ~^d;
  endfunction

  function automatic logic [FW-1:0] make_frame(input logic [NCH-1:0] d);
`ifdef ID_SAMPLER_PARITY_EN
    return {odd_par(d), d};
`else
    return d;
`endif
  endfunction

  logic [NCH-1:0]  dm_p0, dm_nxt, grp;
  logic            vld_p0, vld_nxt;
  logic            selerr_p0, selerr_nxt;
  logic            sel_ok;
  state_t          state_p0, state_nxt;
  logic [FW-1:0]   sh_p0, sh_nxt;
  logic [SNW-1:0]  cnt_p0, cnt_nxt;

  // Stage 0: group select and latch update
  assign sel_ok = ({1'b0, SRC_SEL} < NSRC_W);

  always_comb begin
    grp = '0;
    for (int k = 0; k < NSRC; k++) begin
      if ({1'b0, SRC_SEL} == k[SELW:0]) grp = SRC_DATA[k*NCH +: NCH];
    end
  end

  always_comb begin
    dm_nxt     = dm_p0;
    vld_nxt    = vld_p0;
    selerr_nxt = selerr_p0;
    if (CLEAR) begin
      dm_nxt     = '0;
      vld_nxt    = 1'b0;
      selerr_nxt = 1'b0;
    end else if (SAMPLE) begin
      if (sel_ok) begin
        dm_nxt  = ACCUM ? (dm_p0 | grp) : grp;
        vld_nxt = 1'b1;
      end else begin
        selerr_nxt = 1'b1;
      end
    end
  end

  // Readout FSM next state; the frame is captured from dm_nxt so a SAMPLE or
  // CLEAR on the same edge as READ is reflected in the serial data.
  always_comb begin
    state_nxt = state_p0;
    sh_nxt    = sh_p0;
    cnt_nxt   = cnt_p0;
    unique case (state_p0)
      IDLE: begin
        if (READ) begin
          state_nxt = SHIFT;
          sh_nxt    = make_frame(dm_nxt);
          cnt_nxt   = FRAME_CNT;
        end
      end
      SHIFT: begin
        sh_nxt  = sh_p0 >> 1;
        cnt_nxt = cnt_p0 - SNW'(1);
        if (cnt_p0 == SNW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 1: registers
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      dm_p0     <= '0;
      vld_p0    <= 1'b0;
      selerr_p0 <= 1'b0;
      state_p0  <= IDLE;
      sh_p0     <= '0;
      cnt_p0    <= '0;
    end else begin
      dm_p0     <= dm_nxt;
      vld_p0    <= vld_nxt;
      selerr_p0 <= selerr_nxt;
      state_p0  <= state_nxt;
      sh_p0     <= sh_nxt;
      cnt_p0    <= cnt_nxt;
    end
  end

  assign DM     = dm_p0;
  assign DMN    = ~dm_p0;
  assign VALID  = vld_p0;
  assign SELERR = selerr_p0;
  assign BUSY   = (state_p0 == SHIFT);
  assign SER    = (state_p0 == SHIFT) & sh_p0[0];

endmodule
